// File: rtl/march_pkg.sv
// March C- BIST shared definitions: FSM states, element codes, per-element op table.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package march_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    M0 = 3'd0,
    M1 = 3'd1,
    M2 = 3'd2,
    M3 = 3'd3,
    M4 = 3'd4,
    M5 = 3'd5
  } elem_t;

  // One row of the March C- table. rd_val/wr_val select background 0 or ~0.
  typedef struct packed {
    logic up;
    logic has_rd;
    logic rd_val;
    logic has_wr;
    logic wr_val;
  } elem_op_t;

  localparam int DRAIN_CYCLES = 2;
  localparam int ERR_MAX      = 255;

  function automatic elem_op_t elem_op(input elem_t e);
    elem_op_t o;
    o = '0;
    case (e)
      M0: o = '{up: 1'b1, has_rd: 1'b0, rd_val: 1'b0, has_wr: 1'b1, wr_val: 1'b0};
      M1: o = '{up: 1'b1, has_rd: 1'b1, rd_val: 1'b0, has_wr: 1'b1, wr_val: 1'b1};
      M2: o = '{up: 1'b1, has_rd: 1'b1, rd_val: 1'b1, has_wr: 1'b1, wr_val: 1'b0};
      M3: o = '{up: 1'b0, has_rd: 1'b1, rd_val: 1'b0, has_wr: 1'b1, wr_val: 1'b1};
      M4: o = '{up: 1'b0, has_rd: 1'b1, rd_val: 1'b1, has_wr: 1'b1, wr_val: 1'b0};
      M5: o = '{up: 1'b1, has_rd: 1'b1, rd_val: 1'b0, has_wr: 1'b0, wr_val: 1'b0};
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/march_cmp_pipe.sv
// Read-compare pipeline and error bookkeeping for the March BIST.
// Latency: read info delayed 2 cycles to meet rdata, compare result registered 1 edge later.
// Backpressure: none; one read may enter per cycle.
// Ports: rd_issue/exp/addr/elem describe the read on the bus this cycle, rdata is the
// memory output, clr starts a new run, fail/fail_addr/fail_elem/err_count are results.
module march_cmp_pipe
  import march_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  rd_issue,
  input  logic [DATA_WIDTH-1:0] exp,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            elem,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [7:0]            err_count
);

  logic                  s1_vld, s2_vld;
  logic [DATA_WIDTH-1:0] s1_exp, s2_exp;
  logic [ADDR_WIDTH-1:0] s1_addr, s2_addr;
  logic [2:0]            s1_elem, s2_elem;
  logic                  mismatch;

  // Stage 2 lines up with the cycle in which the memory presents the read data.
  assign mismatch = s2_vld && (rdata != s2_exp);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      s1_exp    <= '0;
      s2_exp    <= '0;
      s1_addr   <= '0;
      s2_addr   <= '0;
      s1_elem   <= '0;
      s2_elem   <= '0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      err_count <= '0;
    end else begin
      s1_vld  <= rd_issue;
      s1_exp  <= exp;
      s1_addr <= addr;
      s1_elem <= elem;
      s2_vld  <= s1_vld;
      s2_exp  <= s1_exp;
      s2_addr <= s1_addr;
      s2_elem <= s1_elem;
      if (clr) begin
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_elem <= '0;
        err_count <= '0;
      end else if (mismatch) begin
        fail <= 1'b1;
        // Location is captured only for the first mismatch of the run.
        if (!fail) begin
          fail_addr <= s2_addr;
          fail_elem <= s2_elem;
        end
        if (err_count != 8'(ERR_MAX)) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: rtl/march_bist_ctrl.sv
// March C- memory BIST controller: sequences six elements, one memory op per cycle.
// Latency: 6 + 10*(LAST_ADDR+1) + 2 busy cycles from start to done.
// Backpressure: none; start is ignored while busy.
// Ports: start requests a run; write_read/address/wdata drive the memory, rdata returns
// from it; busy/done report progress; fail/fail_addr/fail_elem/err_count report faults.
module march_bist_ctrl
  import march_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int LAST_ADDR  = 2**ADDR_WIDTH-1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  write_read,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [7:0]            err_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(LAST_ADDR);
  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);

  state_t     state;
  elem_t      elem;
  elem_t      elem_nxt;
  elem_op_t   cur;
  elem_op_t   nxt;
  logic       phase;      // 1 = second op (write) of a two-op element
  logic [1:0] drain_cnt;
  logic       two_op;
  logic       accept;
  logic       rd_issue;
  logic [ADDR_WIDTH-1:0] end_addr;

  assign cur      = elem_op(elem);
  assign elem_nxt = elem_t'(3'(elem) + 3'd1);
  assign nxt      = elem_op(elem_nxt);
  assign two_op   = cur.has_rd && cur.has_wr;
  assign end_addr = cur.up ? LAST : '0;
  assign accept   = ((state == IDLE) || (state == DONE)) && start;
  assign rd_issue = (state == RUN) && !write_read;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      elem       <= M0;
      phase      <= 1'b0;
      drain_cnt  <= '0;
      write_read <= 1'b0;
      address    <= '0;
      wdata      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= SETUP;
            elem       <= M0;
            phase      <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            write_read <= 1'b0;
            address    <= '0;
            wdata      <= {DATA_WIDTH{elem_op(M0).wr_val}};
          end
        end
        SETUP: begin
          // wdata was loaded on entry so the memory's wdata register is primed.
          state      <= RUN;
          phase      <= 1'b0;
          address    <= cur.up ? '0 : LAST;
          write_read <= !cur.has_rd;
        end
        RUN: begin
          if (two_op && !phase) begin
            phase      <= 1'b1;
            write_read <= 1'b1;
          end else if (address == end_addr) begin
            phase      <= 1'b0;
            write_read <= 1'b0;
            address    <= '0;
            if (elem == M5) begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end else begin
              state <= SETUP;
              elem  <= elem_nxt;
              wdata <= {DATA_WIDTH{nxt.wr_val}};
            end
          end else begin
            phase      <= 1'b0;
            address    <= cur.up ? (address + A_ONE) : (address - A_ONE);
            write_read <= !cur.has_rd;
          end
        end
        DRAIN: begin
          // Lets the last reads of M5 reach the comparator before done rises.
          if (drain_cnt == 2'(DRAIN_CYCLES-1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  march_cmp_pipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_cmp (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .rd_issue  (rd_issue),
    .exp       ({DATA_WIDTH{cur.rd_val}}),
    .addr      (address),
    .elem      (3'(elem)),
    .rdata     (rdata),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .err_count (err_count)
  );

endmodule
